// File: rtl/dbg_wb_pkg.sv
// dbg_wb_pkg: shared definitions for the JTAG debug-to-Wishbone bridge.
//   - DR field offsets (write-enable bit, address LSB, data LSB for the 32/32 build)
//   - status bit indices returned on Capture-DR
//   - bus state enum
package dbg_wb_pkg;

   // DR layout, LSB first on the scan chain: {wdata, adr, we}
   localparam int unsigned WE_BIT  = 0;
   localparam int unsigned ADR_LSB = 1;
   localparam int unsigned DAT_LSB = 33;

   // Status nibble returned in the low bits of every capture
   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_ERR  = 1;
   localparam int unsigned ST_OVR  = 2;
   localparam int unsigned ST_TMO  = 3;
   localparam int unsigned ST_W    = 4;

   typedef enum logic {
      IDLE,
      BUS
   } state_e;

endpackage

// File: rtl/dbg_sync2.sv
// dbg_sync2: 1-bit two-flop synchroniser with synchronous active-high reset.
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous active-high reset (output clears to 0)
//   d    in   asynchronous input
//   q    out  synchronised output, two clk edges after d
module dbg_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dbg_wb_bridge.sv
// dbg_wb_bridge: debug data register behind the JTAG TAP. Implements a DR_W-bit
// shift DR (LSB first) on the TAP chain; every Update-DR launches one single-beat
// Wishbone read or write. All TAP inputs are oversampled on wb_clk_i, so the block
// is fully synchronous to the bus clock. Read data and status come back on the
// next Capture-DR as {rdata, timeout, overrun, bus_err, busy}, zero-extended.
//
// Optional feature: define DBG_WB_TIMEOUT_EN to build a bus timeout counter that
// abandons a cycle after TIMEOUT_CYC clocks and sets timeout + bus_err. Without it,
// status bit 3 reads 0 and a cycle waits for ack/err indefinitely.
//
// Ports:
//   wb_clk_i        in   system clock (>= 8x TCK)
//   wb_rst_i        in   synchronous active-high reset
//   tck_i           in   JTAG TCK (asynchronous)
//   tdi_i           in   serial data into the DR
//   shift_dr_i      in   TAP Shift-DR indication
//   capture_dr_i    in   TAP Capture-DR indication
//   update_dr_i     in   TAP Update-DR indication
//   debug_select_i  in   debug instruction active
//   debug_tdo_o     out  DR serial output (sr[0])
//   wb_cyc_o/stb_o/we_o, wb_adr_o, wb_dat_o, wb_sel_o   Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i                         Wishbone slave response
module dbg_wb_bridge
   import dbg_wb_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DR_W        = 1 + ADDR_W + DATA_W,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              tck_i,
   input  logic              tdi_i,
   input  logic              shift_dr_i,
   input  logic              capture_dr_i,
   input  logic              update_dr_i,
   input  logic              debug_select_i,
   output logic              debug_tdo_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [3:0]        wb_sel_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   localparam int unsigned WDAT_LSB = ADR_LSB + ADDR_W;

   // ---------------------------------------------------------------------------
   // TAP signal synchronisation and TCK edge detect
   // ---------------------------------------------------------------------------
   logic tck_s, tdi_s, shift_s, capture_s, update_s, select_s;
   logic tck_prev;

   dbg_sync2 u_sync_tck (.clk(wb_clk_i), .rst(wb_rst_i), .d(tck_i),          .q(tck_s));
   dbg_sync2 u_sync_tdi (.clk(wb_clk_i), .rst(wb_rst_i), .d(tdi_i),          .q(tdi_s));
   dbg_sync2 u_sync_shf (.clk(wb_clk_i), .rst(wb_rst_i), .d(shift_dr_i),     .q(shift_s));
   dbg_sync2 u_sync_cap (.clk(wb_clk_i), .rst(wb_rst_i), .d(capture_dr_i),   .q(capture_s));
   dbg_sync2 u_sync_upd (.clk(wb_clk_i), .rst(wb_rst_i), .d(update_dr_i),    .q(update_s));
   dbg_sync2 u_sync_sel (.clk(wb_clk_i), .rst(wb_rst_i), .d(debug_select_i), .q(select_s));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) tck_prev <= 1'b0;
      else          tck_prev <= tck_s;
   end

   logic tck_rise;
   logic dr_capture, dr_shift, dr_update;

   // One DR action per TCK edge; capture outranks shift outranks update should the
   // TAP ever present more than one indication at once.
   always_comb begin
      tck_rise   = tck_s & ~tck_prev;
      dr_capture = tck_rise & select_s & capture_s;
      dr_shift   = tck_rise & select_s & shift_s & ~capture_s;
      dr_update  = tck_rise & select_s & update_s & ~capture_s & ~shift_s;
   end

   // ---------------------------------------------------------------------------
   // Shift register, sticky status, bus FSM
   // ---------------------------------------------------------------------------
   state_e            state;
   logic [DR_W-1:0]   sr;
   logic [DATA_W-1:0] rdata;
   logic              err_st, ovr_st, tmo;
   logic [ST_W-1:0]   status;

`ifdef DBG_WB_TIMEOUT_EN
   localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
   logic [CNT_W-1:0] bus_cnt;
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      status          = '0;
      status[ST_BUSY] = (state == BUS);
      status[ST_ERR]  = err_st;
      status[ST_OVR]  = ovr_st;
      status[ST_TMO]  = tmo;
   end

   // sr only moves on qualified TCK edges, so its LSB already behaves as a
   // registered TDO that changes on tck_rise alone.
   assign debug_tdo_o = sr[0];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         sr       <= '0;
         rdata    <= '0;
         err_st   <= 1'b0;
         ovr_st   <= 1'b0;
`ifdef DBG_WB_TIMEOUT_EN
         tmo      <= 1'b0;
         bus_cnt  <= '0;
`endif
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= 4'h0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
      end else begin
         // Capture snapshots the pre-clear stickies; any set below in the same
         // cycle overrides the clear because it is assigned later.
         if (dr_capture) begin
            sr     <= DR_W'({rdata, status});
            err_st <= 1'b0;
            ovr_st <= 1'b0;
`ifdef DBG_WB_TIMEOUT_EN
            tmo    <= 1'b0;
`endif
         end else if (dr_shift) begin
            sr <= {tdi_s, sr[DR_W-1:1]};
         end

         case (state)
            IDLE: begin
               if (dr_update) begin
                  wb_we_o  <= sr[WE_BIT];
                  wb_adr_o <= sr[ADR_LSB +: ADDR_W];
                  wb_dat_o <= sr[WDAT_LSB +: DATA_W];
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_sel_o <= 4'hF;
`ifdef DBG_WB_TIMEOUT_EN
                  bus_cnt  <= '0;
`endif
                  state    <= BUS;
               end
            end
            BUS: begin
               if (dr_update) ovr_st <= 1'b1;
               if (wb_err_i) begin
                  err_st   <= 1'b1;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'h0;
                  state    <= IDLE;
               end else if (wb_ack_i) begin
                  if (!wb_we_o) rdata <= wb_dat_i;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'h0;
                  state    <= IDLE;
`ifdef DBG_WB_TIMEOUT_EN
               end else if (bus_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  // TIMEOUT_CYC cycles with cyc high and no response
                  tmo      <= 1'b1;
                  err_st   <= 1'b1;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'h0;
                  state    <= IDLE;
               end else begin
                  bus_cnt <= bus_cnt + 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
